ram_fill_writer: RTL and testbench

- Write-side counterpart to the ROM read path (address generator + ROM + display).
- Accepts a stream of data words over a valid/ready handshake and generates sequential write addresses.
- Drives a synchronous single-port RAM write interface (we/waddr/wdata).
- Reports fill progress (count, busy, done) so a display stage can read the stored contents back afterwards.

---
 rtl/ram_fill_writer_pkg.sv | 13 +
 rtl/ram_fill_writer_waddr_counter.sv | 35 +++
 rtl/ram_fill_writer.sv | 113 +++++++++++
 tb/tb_ram_fill_writer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_fill_writer_pkg.sv
// Shared definitions for the RAM fill writer and the read-side address generator.
package ram_fill_writer_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

endpackage

// File: rtl/ram_fill_writer_waddr_counter.sv
// Write-address counter: clear, increment, wrap after DEPTH-1, terminal-count flag.
module waddr_counter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clr) begin
      addr_d = '0;
    end else if (inc) begin
      addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  assign addr = addr_q;
  assign last = (addr_q == LAST_ADDR);

endmodule

// File: rtl/ram_fill_writer.sv
// Streams handshaked words into a single-port RAM at sequential addresses and reports fill progress.
module ram_fill_writer
  import ram_fill_writer_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 256,
  parameter bit          WRAP   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              wrapped
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  fill_state_e       state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wrapped_q, wrapped_d;

  logic              cnt_clr;
  logic              cnt_inc;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_last;

  waddr_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_waddr_counter (
    .clk   (clk),
    .rst_n (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .addr  (cnt_addr),
    .last  (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    count_d   = count_q;
    wrapped_d = wrapped_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          cnt_inc = 1'b1;
          we_d    = 1'b1;
          waddr_d = cnt_addr;
          wdata_d = in_data;
          if (count_q != DEPTH_C) count_d = count_q + (ADDR_W + 1)'(1);
          // A saturated count means every address was written once: this write is past the wrap.
          if (WRAP && (count_q == DEPTH_C)) wrapped_d = 1'b1;
          if (!WRAP && cnt_last) state_d = ST_DONE;
        end
        if (stop) state_d = ST_DONE;
      end
      default: begin
        if (start) begin
          state_d   = ST_FILL;
          count_d   = '0;
          wrapped_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign in_ready = (state_q == ST_FILL);
  assign busy     = (state_q == ST_FILL);
  assign done     = (state_q == ST_DONE);
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign count    = count_q;
  assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_ram_fill_writer.sv
// Bench for ram_fill_writer: a stop-mode and a wrap-mode instance (DEPTH=4) share stimulus and a word-count model.
module tb_ram_fill_writer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic       in_ready_o [2];
  logic       we_o       [2];
  logic [7:0] waddr_o    [2];
  logic [7:0] wdata_o    [2];
  logic [8:0] count_o    [2];
  logic       busy_o     [2];
  logic       done_o     [2];
  logic       wrapped_o  [2];

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ram_fill_writer #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WRAP(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_o[0]), .we(we_o[0]), .waddr(waddr_o[0]), .wdata(wdata_o[0]),
    .count(count_o[0]), .busy(busy_o[0]), .done(done_o[0]), .wrapped(wrapped_o[0]));

  ram_fill_writer #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WRAP(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_o[1]), .we(we_o[1]), .waddr(waddr_o[1]), .wdata(wdata_o[1]),
    .count(count_o[1]), .busy(busy_o[1]), .done(done_o[1]), .wrapped(wrapped_o[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a fill is a run of n accepted words; word n lands at n mod DEPTH.
  bit         filling [2];
  bit         finished[2];
  int         nwr     [2];
  logic       e_we    [2];
  logic [7:0] e_waddr [2];
  logic [7:0] e_wdata [2];
  int         e_count [2];
  logic       e_wrap  [2];

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        filling[i] = 0; finished[i] = 0; nwr[i] = 0;
        e_we[i] = 0; e_waddr[i] = 0; e_wdata[i] = 0; e_count[i] = 0; e_wrap[i] = 0;
      end else begin
        e_we[i] = 0;
        if (filling[i]) begin
          if (in_valid) begin
            e_we[i] = 1;
            e_waddr[i] = 8'(nwr[i] % DEPTH);
            e_wdata[i] = in_data;
            e_count[i] = (nwr[i] + 1 < DEPTH) ? nwr[i] + 1 : DEPTH;
            if (i == 1 && nwr[i] >= DEPTH) e_wrap[i] = 1;
            if (i == 0 && nwr[i] + 1 == DEPTH) begin filling[i] = 0; finished[i] = 1; end
            nwr[i]++;
          end
          if (stop) begin filling[i] = 0; finished[i] = 1; end
        end else if (start) begin
          filling[i] = 1; finished[i] = 0; nwr[i] = 0; e_count[i] = 0; e_wrap[i] = 0;
        end
      end
    end
  end

  logic [7:0] log1[$];

  always @(posedge clk) begin
    #1;
    if (we_o[1] === 1'b1) log1.push_back(waddr_o[1]);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cycle_outputs[%0d]", i),
            {2'b0, in_ready_o[i], we_o[i], waddr_o[i], wdata_o[i], count_o[i], busy_o[i], done_o[i], wrapped_o[i]},
            {2'b0, filling[i], e_we[i], e_waddr[i], e_wdata[i], 9'(e_count[i]), filling[i], finished[i], e_wrap[i]});
      end
    end
  end

  task automatic cyc(input bit s, input bit p, input bit v, input logic [7:0] d);
    @(negedge clk);
    start = s; stop = p; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] wrap_exp[6];

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_we", we_o[0], 1'b0);
    chk("reset_count", count_o[1], 9'd0);
    chk("reset_busy", busy_o[0], 1'b0);
    chk("reset_in_ready", in_ready_o[1], 1'b0);
    chk_en = 1'b1;
    @(negedge clk) rst = 1'b1;

    // Basic fill
    cyc(0, 0, 1, 8'hEE);
    chk("idle_ignores_valid", we_o[0], 1'b0);
    cyc(1, 0, 0, 8'h00);
    chk("ready_after_start", in_ready_o[0], 1'b1);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] d;
      d = 8'(8'h11 * (k + 1));
      cyc(0, 0, 1, d);
      chk("basic_waddr", waddr_o[0], 8'(k));
      chk("basic_wdata", wdata_o[0], d);
    end
    chk("basic_done", done_o[0], 1'b1);
    chk("basic_count", count_o[0], 9'd4);
    chk("basic_ready_low", in_ready_o[0], 1'b0);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);

    // Gapped valid
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h5A);
    chk("gap_we1", we_o[0], 1'b1);
    cyc(0, 0, 0, 8'h00);
    chk("gap_we0", we_o[0], 1'b0);
    chk("gap_hold", waddr_o[0], 8'd0);
    cyc(0, 0, 1, 8'hA5);
    chk("gap_waddr2", waddr_o[0], 8'd1);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);

    // Early stop on the third word
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h31);
    cyc(0, 0, 1, 8'h32);
    cyc(0, 1, 1, 8'h33);
    chk("stop_waddr", waddr_o[0], 8'd2);
    chk("stop_wdata", wdata_o[0], 8'h33);
    chk("stop_done", done_o[0], 1'b1);
    chk("stop_count", count_o[0], 9'd3);
    cyc(0, 0, 1, 8'h99);
    chk("stop_no_write", we_o[1], 1'b0);

    // Wrap
    cyc(1, 0, 0, 8'h00);
    log1.delete();
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 1, 8'(k + 1));
      if (k == 3) chk("wrap_not_yet", wrapped_o[1], 1'b0);
      if (k == 4) chk("wrap_set", wrapped_o[1], 1'b1);
    end
    wrap_exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
    chk("wrap_log_len", log1.size(), 6);
    for (int k = 0; k < 6 && k < log1.size(); k++) chk("wrap_seq", log1[k], wrap_exp[k]);
    chk("wrap_count", count_o[1], 9'd4);
    chk("wrap_busy", busy_o[1], 1'b1);
    cyc(0, 0, 0, 8'h00);
    chk("wrap_still_busy", busy_o[1], 1'b1);
    cyc(0, 1, 0, 8'h00);
    chk("wrap_stopped", done_o[1], 1'b1);

    // Restart from DONE, then start during FILL
    cyc(1, 0, 0, 8'h00);
    chk("restart_done_low", done_o[1], 1'b0);
    chk("restart_ready", in_ready_o[1], 1'b1);
    chk("restart_wrapped_clr", wrapped_o[1], 1'b0);
    cyc(0, 0, 1, 8'hC1);
    chk("restart_waddr", waddr_o[1], 8'd0);
    chk("restart_count", count_o[1], 9'd1);
    cyc(1, 0, 1, 8'hC2);
    chk("start_in_fill_waddr", waddr_o[1], 8'd1);
    chk("start_in_fill_count", count_o[1], 9'd2);
    cyc(0, 1, 0, 8'h00);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom % 16) == 0, ($urandom % 12) == 0, ($urandom % 3) != 0, 8'($urandom));
    end

    // Asynchronous reset in the middle of a fill
    cyc(0, 1, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, 8'(8'h70 + k));
    chk("pre_reset_we", we_o[1], 1'b1);
    #3 rst = 1'b0;
    #1;
    chk("async_we", we_o[1], 1'b0);
    chk("async_count", count_o[1], 9'd0);
    chk("async_busy", busy_o[1], 1'b0);
    chk("async_done", done_o[0], 1'b0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    cyc(0, 0, 1, 8'h55);
    chk("post_reset_idle", in_ready_o[1], 1'b0);
    chk("post_reset_no_write", we_o[1], 1'b0);
    cyc(0, 0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
